// File: rtl/apb_master_bridge.sv
// APB master engine: buffers register-access requests in a small FIFO and runs
// them one at a time on an APB master port, returning one response per request.
module apb_master_bridge #(
  parameter int REQ_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_write,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic [$clog2(REQ_DEPTH):0] fifo_level,
  output logic                       m_apb_psel,
  output logic                       m_apb_penable,
  output logic                       m_apb_pwrite,
  output logic [31:0]                m_apb_paddr,
  output logic [31:0]                m_apb_pwdata,
  input  logic                       m_apb_pready,
  input  logic [31:0]                m_apb_prdata
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

  entry_t           mem [REQ_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic [CNT_W-1:0] wait_cnt;
  state_t           state, next_state;
  logic             push, pop, fifo_empty, expired, done;

  assign fifo_empty = (count == '0);
  assign req_ready  = (count != LVL_W'(REQ_DEPTH));
  assign fifo_level = count;
  assign push       = req_valid && req_ready;
  assign pop        = (next_state == SETUP);
  assign head       = mem[rd_ptr];
  // The TIMEOUT-th consecutive wait cycle aborts, unless pready arrives on it.
  assign expired    = (TIMEOUT != 0) && !m_apb_pready && (wait_cnt == CNT_LAST);
  assign done       = (state == ACCESS) && (m_apb_pready || expired);
  assign busy       = !fifo_empty || (state != IDLE);

  // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (m_apb_pready || expired) next_state = RESP;
      RESP:    if (rsp_ready) next_state = fifo_empty ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_apb_psel    = 1'b0;
    m_apb_penable = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      SETUP:   m_apb_psel = 1'b1;
      ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // APB address/data load only on pop, so they keep their last value between transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_apb_pwrite <= 1'b0;
      m_apb_paddr  <= '0;
      m_apb_pwdata <= '0;
      wait_cnt     <= '0;
      rsp_rdata    <= '0;
      rsp_write    <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      if (pop) begin
        m_apb_pwrite <= head.write;
        m_apb_paddr  <= head.addr;
        m_apb_pwdata <= head.wdata;
      end
      if (state == SETUP)                        wait_cnt <= '0;
      else if (state == ACCESS && !m_apb_pready) wait_cnt <= wait_cnt + 1'b1;
      if (done) begin
        rsp_rdata   <= (m_apb_pready && !m_apb_pwrite) ? m_apb_prdata : '0;
        rsp_write   <= m_apb_pwrite;
        rsp_timeout <= !m_apb_pready;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a request-level scoreboard.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int REQ_DEPTH = 4;
  localparam int TIMEOUT   = 255;
  localparam int NEVER     = 100000;
  localparam int NRAND     = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [$clog2(REQ_DEPTH):0] fifo_level;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;

  always #5 clk = ~clk;

  apb_master_bridge #(.REQ_DEPTH(REQ_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .busy(busy), .fifo_level(fifo_level),
    .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
    .m_apb_paddr(paddr), .m_apb_pwdata(pwdata),
    .m_apb_pready(pready), .m_apb_prdata(prdata)
  );

  typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic write; logic [31:0] rdata; logic timeout; } rsp_t;
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  rsp_t exp_q[$];
  req_t apb_q[$];
  vec_t vecs[8];

  int checks = 0, errors = 0, cyc = 0;
  int wait_override = -1, cur_wait = 0, acc_n = 0;
  logic [31:0] setup_addr = '0;
  int rsp_count = 0, last_rsp_cyc = 0;
  int lat, acc_cycles, idx, max_lvl, base, k, prev, sent;
  int rsp_cyc[6];
  logic acc;

  function automatic logic [31:0] slave_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  // Slave wait states: forced value, never-ready region 0xFxxx_xxxx, else addr[3:2].
  function automatic int wait_for(input logic [31:0] a);
    if (wait_override >= 0) return wait_override;
    if (a[31:28] == 4'hF) return NEVER;
    return int'(a[3:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One clock: slave model, push/response scoreboard, then advance to edge+1.
  task automatic cycle();
    if (penable) check("penable_needs_psel", 32'(psel), 32'd1);
    if (psel && !penable) begin
      setup_addr = paddr;
      acc_n      = 0;
      cur_wait   = wait_for(paddr);
      pready     = 1'b0;
      prdata     = $urandom;
    end else if (psel && penable) begin
      check("addr_stable", paddr, setup_addr);
      if (acc_n == cur_wait) begin
        pready = 1'b1;
        prdata = pwrite ? $urandom : slave_val(paddr);
        check("apb_expected", 32'(apb_q.size() != 0), 32'd1);
        if (apb_q.size() != 0) begin
          req_t r = apb_q.pop_front();
          check("apb_write", 32'(pwrite), 32'(r.write));
          check("apb_addr", paddr, r.addr);
          if (r.write) check("apb_wdata", pwdata, r.wdata);
        end
      end else begin
        pready = 1'b0;
        prdata = $urandom;
      end
      acc_n++;
    end else begin
      pready = 1'b0;
      prdata = $urandom;
    end
    if (req_valid && req_ready) begin
      int w  = wait_for(req_addr);
      bit to = (TIMEOUT != 0) && (w >= TIMEOUT);
      exp_q.push_back('{write: req_write,
                        rdata: (req_write || to) ? 32'h0 : slave_val(req_addr),
                        timeout: to});
      if (!to) apb_q.push_back('{write: req_write, addr: req_addr, wdata: req_wdata});
    end
    if (rsp_valid && rsp_ready) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        rsp_t e = exp_q.pop_front();
        check("rsp_write", 32'(rsp_write), 32'(e.write));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
      end
      rsp_count++;
      last_rsp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_fill(input int i);
    if (i < 6) begin
      req_valid = 1'b1;
      req_write = (i == 2);
      req_addr  = 32'h100 + 32'(i * 4);
      req_wdata = 32'hC0DE_0000 + 32'(i);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  initial begin
    //        write  addr           wdata          wait   exp_rdata      to    lat  acc
    vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_001F, 0,     32'h0,         1'b0, 4,   1};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         3,     32'hA5A5_0003, 1'b0, 7,   4};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         0,     32'hA5A5_0013, 1'b0, 4,   1};
    vecs[3] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         2,     32'h5A5A_FFF3, 1'b0, 6,   3};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1,     32'h0,         1'b0, 5,   2};
    vecs[5] = '{1'b0, 32'h1234_5678, 32'h0,         254,   32'hB791_567B, 1'b0, 258, 255};
    vecs[6] = '{1'b0, 32'h0000_0020, 32'h0,         NEVER, 32'h0,         1'b1, 258, 255};
    vecs[7] = '{1'b1, 32'h0000_0044, 32'h1234_0000, NEVER, 32'h0,         1'b1, 258, 255};

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_flags", 32'({rsp_write, rsp_timeout}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Directed single transactions.
    for (int i = 0; i < 8; i++) begin
      wait_override = vecs[i].wait_n;
      req_valid = 1'b1; req_write = vecs[i].write;
      req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'd1);
      cycle();
      req_valid = 1'b0;
      lat = 1; acc_cycles = 0;
      while (!rsp_valid && lat < 400) begin
        if (lat == 2) begin
          check($sformatf("vec%0d_setup_sel", i), 32'({psel, penable}), 32'b10);
          check($sformatf("vec%0d_setup_addr", i), paddr, vecs[i].addr);
          check($sformatf("vec%0d_setup_write", i), 32'(pwrite), 32'(vecs[i].write));
        end
        if (penable) acc_cycles++;
        cycle();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_access_cycles", i), 32'(acc_cycles), 32'(vecs[i].exp_acc));
      check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_timeout", i), 32'(rsp_timeout), 32'(vecs[i].exp_to));
      check($sformatf("vec%0d_rsp_write", i), 32'(rsp_write), 32'(vecs[i].write));
      check($sformatf("vec%0d_resp_psel", i), 32'({psel, penable}), 32'b00);
      cycle();
      check($sformatf("vec%0d_rsp_held", i), 32'(rsp_valid), 32'd1);
      check($sformatf("vec%0d_rdata_held", i), rsp_rdata, vecs[i].exp_rdata);
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      check($sformatf("vec%0d_idle_valid", i), 32'(rsp_valid), 32'd0);
      check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_idle_psel", i), 32'(psel), 32'd0);
      check($sformatf("vec%0d_addr_retained", i), paddr, vecs[i].addr);
    end

    // Six back-to-back requests with responses stalled, then drained.
    wait_override = 0; rsp_ready = 1'b0; idx = 0; max_lvl = 0;
    for (int c = 0; c < 20; c++) begin
      drive_fill(idx);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      acc = req_valid && req_ready;
      cycle();
      if (acc) idx++;
    end
    check("fill_accepted", 32'(idx), 32'd5);
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_max_level", 32'(max_lvl), 32'd4);
    check("fill_req_ready", 32'(req_ready), 32'd0);
    check("fill_rsp_held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1; base = rsp_count; k = 0;
    for (int c = 0; c < 60 && rsp_count < base + 6; c++) begin
      drive_fill(idx);
      acc = req_valid && req_ready;
      prev = rsp_count;
      cycle();
      if (acc) idx++;
      if (rsp_count != prev && k < 6) begin
        rsp_cyc[k] = last_rsp_cyc;
        k++;
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("fill_rsp_count", 32'(rsp_count - base), 32'd6);
    for (int i = 1; i < 6; i++)
      check($sformatf("fill_spacing%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
    cycle();
    check("fill_idle_busy", 32'(busy), 32'd0);

    // Request arriving in RESP with an empty FIFO goes IDLE then SETUP.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_wdata = '0;
    cycle();
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !rsp_valid; c++) cycle();
    check("late_in_resp", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_addr = 32'h304; rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("late_idle_psel", 32'(psel), 32'd0);
    check("late_idle_level", 32'(fifo_level), 32'd1);
    check("late_idle_busy", 32'(busy), 32'd1);
    cycle();
    check("late_setup_sel", 32'({psel, penable}), 32'b10);
    check("late_setup_addr", paddr, 32'h304);
    check("late_setup_level", 32'(fifo_level), 32'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && busy; c++) cycle();
    rsp_ready = 1'b0;
    check("late_drained", 32'(exp_q.size()), 32'd0);

    // Timed-out request followed by a queued normal read.
    wait_override = -1; rsp_ready = 1'b1; base = rsp_count;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hF000_0020;
    cycle();
    req_addr = 32'h0000_0024;
    cycle();
    req_valid = 1'b0;
    for (int c = 0; c < 700 && rsp_count < base + 2; c++) cycle();
    rsp_ready = 1'b0;
    check("to_then_normal_count", 32'(rsp_count - base), 32'd2);

    // Reset during ACCESS with two requests queued.
    wait_override = NEVER; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400 + 32'(i * 4);
      cycle();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !(penable && fifo_level == 2); c++) cycle();
    check("pre_reset_access", 32'({penable, fifo_level == 2}), 32'b11);
    #2 rst = 1'b0;
    #1;
    check("async_psel", 32'(psel), 32'd0);
    check("async_penable", 32'(penable), 32'd0);
    exp_q.delete(); apb_q.delete(); pready = 1'b0; acc_n = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_level", 32'(fifo_level), 32'd0);
    check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);
    cycle();
    check("post_reset_quiet", 32'({psel, rsp_valid}), 32'b00);

    // Randomized traffic against the scoreboard.
    wait_override = -1; base = rsp_count; sent = 0;
    for (int c = 0; c < 6000 && (sent < NRAND || rsp_count < base + NRAND); c++) begin
      if (!req_valid && sent < NRAND && $urandom_range(0, 9) < 7) begin
        req_valid = 1'b1;
        req_write = $urandom_range(0, 1) == 1;
        req_addr  = $urandom & 32'h7FFF_FFFF;
        req_wdata = $urandom;
      end
      rsp_ready = $urandom_range(0, 9) < 6;
      check("req_ready_rule", 32'(req_ready), 32'(fifo_level != 3'(REQ_DEPTH)));
      acc = req_valid && req_ready;
      cycle();
      if (acc) begin
        req_valid = 1'b0;
        sent++;
      end
    end
    rsp_ready = 1'b0;
    check("rand_rsp_count", 32'(rsp_count - base), 32'(NRAND));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    cycle();
    check("rand_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
